// File: rtl/rab_pkg.sv
// rtl/rab_pkg.sv - shared state type and response codes for the R-channel drop injector
//
// Contents:
//   rab_state_e  : PASS (master R channel forwarded) / DROP (injecting a synthetic burst)
//   RESP_OKAY    : 2'b00
//   RESP_SLVERR  : 2'b10
//   drop_resp()  : response code for an injected beat, selected by the prefetch flag
package rab_pkg;

  typedef enum logic {
    ST_PASS = 1'b0,
    ST_DROP = 1'b1
  } rab_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Prefetch reads are answered benignly so a speculative access never raises a fault.
  function automatic logic [1:0] drop_resp(input logic prefetch);
    return prefetch ? RESP_OKAY : RESP_SLVERR;
  endfunction

endpackage

// File: rtl/axi4_r_sender_if.sv
// rtl/axi4_r_sender_if.sv - AXI4 R channel bundle
//
// Signals:
//   rid, rdata, rresp, rlast, ruser, rvalid : driven by the channel source
//   rready                                  : driven by the channel sink
// Modports:
//   master : channel source (drives payload/valid, receives ready)
//   slave  : channel sink   (receives payload/valid, drives ready)
interface axi4_r_sender_if #(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 10,
  parameter int AXI_USER_WIDTH = 4
) ();

  logic [AXI_ID_WIDTH-1:0]   rid;
  logic [AXI_DATA_WIDTH-1:0] rdata;
  logic [1:0]                rresp;
  logic                      rlast;
  logic [AXI_USER_WIDTH-1:0] ruser;
  logic                      rvalid;
  logic                      rready;

  modport master (
    output rid, rdata, rresp, rlast, ruser, rvalid,
    input  rready
  );

  modport slave (
    input  rid, rdata, rresp, rlast, ruser, rvalid,
    output rready
  );

endinterface

// File: rtl/axi4_r_drop_fifo.sv
// rtl/axi4_r_drop_fifo.sv - queue of pending dropped reads awaiting an injected response
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   valid_in   : push request (ignored while full)
//   data_in    : entry to push
//   ready_out  : FIFO not full
//   valid_out  : FIFO not empty
//   data_out   : head entry
//   ready_in   : pop request (ignored while empty)
module axi4_r_drop_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready_out,
  output logic             valid_out,
  output logic [WIDTH-1:0] data_out,
  input  logic             ready_in
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when the indices coincide.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_push    = valid_in && !w_full;
  assign w_pop     = ready_in && !w_empty;
  assign ready_out = !w_full;
  assign valid_out = !w_empty;
  assign data_out  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= data_in;
  end

endmodule

// File: rtl/axi4_r_sender.sv
// rtl/axi4_r_sender.sv - R-channel mux that injects zero-data responses for dropped reads
//
// Optional feature macro: AXI4_R_SENDER_PREFETCH_EN (prefetch drops answer OKAY instead of SLVERR).
//
// Ports:
//   axi4_aclk      : clock
//   axi4_arst      : synchronous active-high reset
//   trans_id       : ID of the dropped read
//   trans_len      : ARLEN of the dropped read (burst is trans_len+1 beats)
//   trans_drop     : push strobe for trans_id/trans_len/trans_prefetch
//   trans_prefetch : dropped read is a prefetch
//   drop_ready     : drop queue not full
//   drop_done      : pulse when the last injected beat is accepted
//   s_axi4         : R channel towards the slave port (this block is the source)
//   m_axi4         : R channel from the master port (this block is the sink)
module axi4_r_sender
  import rab_pkg::*;
#(
  parameter int AXI_DATA_WIDTH  = 64,
  parameter int AXI_ID_WIDTH    = 10,
  parameter int AXI_USER_WIDTH  = 4,
  parameter int DROP_FIFO_DEPTH = 4
) (
  input  logic                    axi4_aclk,
  input  logic                    axi4_arst,
  input  logic [AXI_ID_WIDTH-1:0] trans_id,
  input  logic [7:0]              trans_len,
  input  logic                    trans_drop,
  input  logic                    trans_prefetch,
  output logic                    drop_ready,
  output logic                    drop_done,
  axi4_r_sender_if.master         s_axi4,
  axi4_r_sender_if.slave          m_axi4
);

`ifdef AXI4_R_SENDER_PREFETCH_EN
  localparam int ENTRY_W = AXI_ID_WIDTH + 8 + 1;
`else
  localparam int ENTRY_W = AXI_ID_WIDTH + 8;
`endif

  logic [ENTRY_W-1:0]      w_push_entry;
  logic [ENTRY_W-1:0]      w_head;
  logic [AXI_ID_WIDTH-1:0] w_head_id;
  logic [7:0]              w_head_len;
  logic                    w_head_prefetch;
  logic                    w_fifo_valid;
  logic                    w_fifo_ready;
  logic                    w_pop;

  rab_state_e              r_state;
  rab_state_e              w_state_nxt;
  logic [7:0]              r_beat_cnt;
  logic [7:0]              w_beat_cnt_nxt;
  logic                    r_burst_active;
  logic                    w_grant;
  logic                    w_m_rready;
  logic                    w_m_beat;

`ifdef AXI4_R_SENDER_PREFETCH_EN
  assign w_push_entry    = {trans_prefetch, trans_len, trans_id};
  assign w_head_prefetch = w_head[ENTRY_W-1];
`else
  logic w_unused_prefetch;
  assign w_unused_prefetch = trans_prefetch;
  assign w_push_entry      = {trans_len, trans_id};
  assign w_head_prefetch   = 1'b0;
`endif

  assign w_head_id  = w_head[AXI_ID_WIDTH-1:0];
  assign w_head_len = w_head[AXI_ID_WIDTH +: 8];

  axi4_r_drop_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DROP_FIFO_DEPTH)
  ) u_drop_fifo (
    .clk       (axi4_aclk),
    .rst       (axi4_arst),
    .valid_in  (trans_drop),
    .data_in   (w_push_entry),
    .ready_out (w_fifo_ready),
    .valid_out (w_fifo_valid),
    .data_out  (w_head),
    .ready_in  (w_pop)
  );

  // Injection may only start between master bursts so R beats of one ID never interleave.
  assign w_grant  = (r_state == ST_PASS) && w_fifo_valid && !r_burst_active;
  assign w_m_beat = m_axi4.rvalid && w_m_rready;

  always_comb begin
    w_state_nxt    = r_state;
    w_beat_cnt_nxt = r_beat_cnt;
    w_pop          = 1'b0;
    s_axi4.rid     = m_axi4.rid;
    s_axi4.rdata   = m_axi4.rdata;
    s_axi4.rresp   = m_axi4.rresp;
    s_axi4.rlast   = m_axi4.rlast;
    s_axi4.ruser   = m_axi4.ruser;
    s_axi4.rvalid  = m_axi4.rvalid;
    w_m_rready     = s_axi4.rready;

    case (r_state)
      ST_PASS: begin
        // Grant cycle: both directions are blocked for one bubble while beat_cnt loads.
        if (w_grant) begin
          s_axi4.rvalid  = 1'b0;
          w_m_rready     = 1'b0;
          w_state_nxt    = ST_DROP;
          w_beat_cnt_nxt = w_head_len;
        end
      end
      ST_DROP: begin
        s_axi4.rvalid = 1'b1;
        s_axi4.rid    = w_head_id;
        s_axi4.rdata  = '0;
        s_axi4.ruser  = '0;
        s_axi4.rresp  = drop_resp(w_head_prefetch);
        s_axi4.rlast  = (r_beat_cnt == 8'd0);
        w_m_rready    = 1'b0;
        if (s_axi4.rready) begin
          if (r_beat_cnt != 8'd0) begin
            w_beat_cnt_nxt = r_beat_cnt - 8'd1;
          end else begin
            w_pop       = 1'b1;
            w_state_nxt = ST_PASS;
          end
        end
      end
      default: begin
        w_state_nxt = ST_PASS;
      end
    endcase
  end

  always_ff @(posedge axi4_aclk) begin
    if (axi4_arst) begin
      r_state        <= ST_PASS;
      r_beat_cnt     <= 8'd0;
      r_burst_active <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      if (w_m_beat) r_burst_active <= !m_axi4.rlast;
    end
  end

  assign m_axi4.rready = w_m_rready;
  assign drop_ready    = w_fifo_ready;
  // A burst abandoned by reset must not report completion.
  assign drop_done     = w_pop && !axi4_arst;

endmodule

// File: doc/axi4_r_sender.md
AXI4_R_SENDER -- requirements
Module: axi4_r_sender

Interface
REQ-001 AXI_DATA_WIDTH, default 64, R data width in bits.
REQ-002 AXI_ID_WIDTH, default 10, R ID width in bits.
REQ-003 AXI_USER_WIDTH, default 4, R user width in bits.
REQ-004 DROP_FIFO_DEPTH, default 4, number of pending dropped reads, power of two, at least 2.
REQ-005 axi4_aclk  in  1  sole clock; all logic is on the rising edge.
REQ-006 axi4_arst  in  1  reset, synchronous, active-high.
REQ-007 trans_id  in  AXI_ID_WIDTH  ID of the read being dropped.
REQ-008 trans_len  in  8  ARLEN of the dropped read; the burst is trans_len+1 beats.
REQ-009 trans_drop  in  1  push strobe; captures trans_id, trans_len and trans_prefetch.
REQ-010 trans_prefetch  in  1  the dropped read is a prefetch.
REQ-011 drop_ready  out  1  drop FIFO not full.
REQ-012 drop_done  out  1  one-cycle pulse when the last injected beat is accepted.
REQ-013 s_axi4_rid/rdata/rresp/rlast/ruser  out  ID/DATA/2/1/USER  R payload to the slave port.
REQ-014 s_axi4_rvalid  out  1  R valid to the slave port.
REQ-015 s_axi4_rready  in  1  R ready from the slave port.
REQ-016 m_axi4_rid/rdata/rresp/rlast/ruser  in  ID/DATA/2/1/USER  R payload from the master port.
REQ-017 m_axi4_rvalid  in  1  R valid from the master port.
REQ-018 m_axi4_rready  out  1  R ready to the master port.

Function
REQ-019 A push SHALL occur when trans_drop is high and drop_ready is high; trans_drop while full SHALL be ignored; a push and a pop in the same cycle SHALL both take effect.
REQ-020 A burst_active flag SHALL set on a master beat (rvalid, rready, !rlast) and clear on a master beat with rlast.
REQ-021 The FSM SHALL have two states, PASS and DROP, and reset to PASS.
REQ-022 In PASS with no grant, s_axi4_r* SHALL equal m_axi4_r* combinationally and m_axi4_rready SHALL equal s_axi4_rready.
REQ-023 grant = PASS && FIFO non-empty && !burst_active; in a grant cycle s_axi4_rvalid=0 and m_axi4_rready=0; the next state SHALL be DROP and beat_cnt SHALL load the head len.
REQ-024 In DROP: s_axi4_rvalid=1, rid=head id, rdata=0, ruser=0, rlast=(beat_cnt==0), m_axi4_rready=0.
REQ-025 In DROP, rresp SHALL be 2'b10 (SLVERR), except as given in REQ-031.
REQ-026 On a DROP handshake with beat_cnt>0, beat_cnt SHALL decrement by one; with beat_cnt==0 the FIFO SHALL pop, drop_done SHALL pulse, and the state SHALL return to PASS.
REQ-027 Payload SHALL hold stable while s_axi4_rvalid is high and s_axi4_rready is low.
REQ-028 Latency: the first injected beat SHALL be valid 2 cycles after the push into an empty, idle block; back-to-back drops SHALL have exactly one grant bubble between them.
REQ-029 A master burst in progress SHALL never be interleaved; a grant SHALL wait until burst_active clears.

Reset
REQ-030 On axi4_arst: FIFO empty, state PASS, beat_cnt=0, burst_active=0, drop_done=0, drop_ready=1, s_axi4_rvalid=m_axi4_rvalid. Reset during DROP SHALL abandon the burst with no further beats.

Configuration
REQ-031 AXI4_R_SENDER_PREFETCH_EN defined: an entry with prefetch=1 SHALL respond with rresp=2'b00 (OKAY) and zero data. Undefined: trans_prefetch SHALL be ignored, it SHALL not be stored, and every drop SHALL respond SLVERR.

Structure
REQ-032 The package rab_pkg SHALL hold the PASS/DROP state enum and RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
REQ-033 The drop FIFO SHALL be a sub-module, axi4_r_drop_fifo, synchronous active-high reset, exposing valid_out and ready_out.

Verification
REQ-034 Stimulus: drop id=0x05, len=3, s_rready=1. Required: 4 beats on cycles 2-5, rresp=2'b10, rlast on the 4th beat only, drop_done on cycle 5.
REQ-035 Stimulus: master is mid-burst (2 of 8 beats done) when a drop id=0x11, len=0 is pushed. Required: the remaining 6 master beats finish first, then 1 SLVERR beat with rlast=1.
REQ-036 Stimulus: push 5 drops with DROP_FIFO_DEPTH=4 and s_rready=0. Required: drop_ready low after the 4th push, the 5th push is lost, and exactly 4 bursts are emitted once rready rises.
REQ-037 Stimulus: DROP with beat_cnt=2 and s_rready toggling 1,0,1,0,1. Required: the payload holds during stalls and rlast appears on the 3rd accepted beat.
REQ-038 Stimulus: axi4_arst asserted during the 2nd beat of a len=7 drop. Required: s_rvalid falls, the FIFO is empty, and master passthrough resumes the cycle after reset.
REQ-039 Stimulus: with the macro defined, drop id=0x3, len=1, prefetch=1. Required: 2 beats with rresp=2'b00 and rdata=0.
